// File: rtl/pg68k_bus_pkg.sv
// rtl/pg68k_bus_pkg.sv - shared 68030 bus definitions for the DRAM and fast-RAM decoders
// Purpose: DRAM controller state encoding, SIZ codes and the 32-bit-port
//          byte-lane enable table ({SIZ, A[1:0]} -> lanes, bit 0 = D31:24).
// Ports:   none (package).
package pg68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAS,
    ST_CASW,
    ST_CAS,
    ST_PRE,
    ST_RFC,
    ST_RFR
  } dram_state_t;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  // A 32-bit port takes the lanes from the start offset up to the end of the
  // long word; anything past lane 3 is left for the CPU's next bus cycle.
  function automatic logic [3:0] lane_enables(input logic [1:0] siz, input logic [1:0] a);
    logic [2:0] first;
    logic [2:0] stop;
    logic [3:0] en;
    first = {1'b0, a};
    stop  = first + ((siz == SIZ_LONG) ? 3'd4 : {1'b0, siz});
    for (int i = 0; i < 4; i++) begin
      en[i] = (3'(i) >= first) && (3'(i) < stop);
    end
    return en;
  endfunction

endpackage

// File: rtl/dramctl_refresh.sv
// rtl/dramctl_refresh.sv - free-running refresh timer with a sticky pending flag
// Purpose: counts 0..REFRESH_DIV-1 and raises pend at each wrap; pend stays
//          set until the controller acknowledges with clr. Overlapping wraps
//          while pending collapse into one request.
// Ports:   DRAM_CLK, nRST (async, active-low), clr (refresh taken), pend (refresh due).
module dramctl_refresh #(
  parameter int REFRESH_DIV = 780
) (
  input  logic DRAM_CLK,
  input  logic nRST,
  input  logic clr,
  output logic pend
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    // A wrap coinciding with the acknowledge is a fresh request, so set wins.
    pend_d = wrap | (pend_q & ~clr);
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/dramctl.sv
// rtl/dramctl.sv - 68030 DRAM bank controller with CAS-before-RAS refresh
// Purpose: sequences RAS/CAS/WE for a 256 MB bank of four 64 MB sides,
//          terminates with a 32-bit DSACK, and interleaves refresh.
// Ports:   DRAM_CLK, nRST (async, active-low); nDRAMSEL, nAS, nDS, RnW, SIZ, ADDR
//          from the CPU side; MA, nRAS[3:0], nCAS[3:0] (lane 0 = D31:24), nWE
//          to the DRAM; DSACK[1:0] active-high to the bus terminator.
module dramctl
  import pg68k_bus_pkg::*;
#(
  parameter int REFRESH_DIV = 780,
  parameter int TRP         = 3,
  parameter int TRAS_REF    = 4
) (
  input  logic        DRAM_CLK,
  input  logic        nRST,
  input  logic        nDRAMSEL,
  input  logic        nAS,
  input  logic        nDS,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [27:0] ADDR,
  output logic [11:0] MA,
  output logic [3:0]  nRAS,
  output logic [3:0]  nCAS,
  output logic        nWE,
  output logic [1:0]  DSACK
);

  dram_state_t state_q, state_d;
  logic        nsel_q, nas_q, nds_q;
  logic [27:0] addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [1:0]  siz_q, siz_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [11:0] ma_q, ma_d;
  logic [3:0]  nras_q, nras_d;
  logic [3:0]  ncas_q, ncas_d;
  logic        nwe_q, nwe_d;
  logic [1:0]  dsack_q, dsack_d;
  logic        req;
  logic        ref_pend;
  logic        ref_clr;
  logic [3:0]  ras_sel;
  logic [3:0]  lanes;

  dramctl_refresh #(.REFRESH_DIV(REFRESH_DIV)) u_refresh (
    .DRAM_CLK (DRAM_CLK),
    .nRST     (nRST),
    .clr      (ref_clr),
    .pend     (ref_pend)
  );

  assign ref_clr = (state_q == ST_RFC);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    siz_d   = siz_q;
    req     = ~nsel_q & ~nas_q;

    case (state_q)
      ST_IDLE: begin
        // Track the bus while idle so the values present on the exit edge stick.
        addr_d = ADDR;
        rnw_d  = RnW;
        siz_d  = SIZ;
        if (ref_pend)  state_d = ST_RFC;
        else if (req)  state_d = ST_RAS;
      end
      ST_RAS:  state_d = nas_q ? ST_PRE : ST_CASW;
      ST_CASW: begin
        if (nas_q)               state_d = ST_PRE;
        else if (rnw_q || !nds_q) state_d = ST_CAS;
      end
      ST_CAS:  if (nas_q) state_d = ST_PRE;
      ST_PRE:  if (tcnt_q == 8'(TRP - 1)) state_d = ST_IDLE;
      ST_RFC:  state_d = ST_RFR;
      ST_RFR:  if (tcnt_q == 8'(TRAS_REF - 1)) state_d = ST_PRE;
      default: state_d = ST_IDLE;
    endcase

    // Dwell counter restarts on every state change; only PRE and RFR read it.
    tcnt_d = (state_d == state_q) ? tcnt_q + 8'd1 : 8'd0;
  end

  // Strobes are decoded from the next state into flops so they switch on the
  // same edge as the state register and never glitch.
  always_comb begin
    ras_sel = ~(4'b0001 << addr_d[27:26]);
    lanes   = rnw_d ? 4'hF : lane_enables(siz_d, addr_d[1:0]);
    ma_d    = addr_d[25:14];
    nras_d  = 4'hF;
    ncas_d  = 4'hF;
    nwe_d   = 1'b1;
    dsack_d = 2'b00;
    case (state_d)
      ST_RAS:  nras_d = ras_sel;
      ST_CASW: begin
        nras_d = ras_sel;
        ma_d   = addr_d[13:2];
      end
      ST_CAS: begin
        nras_d  = ras_sel;
        ma_d    = addr_d[13:2];
        ncas_d  = ~lanes;
        nwe_d   = rnw_d;
        dsack_d = 2'b11;
      end
      ST_RFC:  ncas_d = 4'h0;
      ST_RFR: begin
        nras_d = 4'h0;
        ncas_d = 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      nsel_q  <= 1'b1;
      nas_q   <= 1'b1;
      nds_q   <= 1'b1;
      addr_q  <= '0;
      rnw_q   <= 1'b1;
      siz_q   <= 2'b00;
      tcnt_q  <= 8'd0;
      ma_q    <= '0;
      nras_q  <= 4'hF;
      ncas_q  <= 4'hF;
      nwe_q   <= 1'b1;
      dsack_q <= 2'b00;
    end else begin
      state_q <= state_d;
      nsel_q  <= nDRAMSEL;
      nas_q   <= nAS;
      nds_q   <= nDS;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      siz_q   <= siz_d;
      tcnt_q  <= tcnt_d;
      ma_q    <= ma_d;
      nras_q  <= nras_d;
      ncas_q  <= ncas_d;
      nwe_q   <= nwe_d;
      dsack_q <= dsack_d;
    end
  end

  assign MA    = ma_q;
  assign nRAS  = nras_q;
  assign nCAS  = ncas_q;
  assign nWE   = nwe_q;
  assign DSACK = dsack_q;

endmodule

// File: doc/dramctl.md
DRAMCTL -- requirements
Module: dramctl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 780, meaning DRAM_CLK cycles between refresh requests (15.6 us at 50 MHz).
REQ-002 SHALL have parameter TRP, default 3, meaning RAS precharge cycles after every access or refresh.
REQ-003 SHALL have parameter TRAS_REF, default 4, meaning cycles nRAS is held low during refresh.
REQ-004 SHALL have port DRAM_CLK  in  1  50 MHz clock; all state advances on its rising edge.
REQ-005 SHALL have port nRST  in  1  reset: asynchronous, active-low.
REQ-006 SHALL have port nDRAMSEL  in  1  bank select from the system controller, already qualified by /AS.
REQ-007 SHALL have ports nAS, nDS, RnW  in  1 each  68030 bus strobes and direction.
REQ-008 SHALL have port SIZ  in  2  68030 transfer size.
REQ-009 SHALL have port ADDR  in  28  byte address within the 256 MB bank.
REQ-010 SHALL have port MA  out  12  multiplexed DRAM address: row = ADDR[25:14], column = ADDR[13:2].
REQ-011 SHALL have port nRAS  out  4  one per 64 MB side, selected by ADDR[27:26].
REQ-012 SHALL have port nCAS  out  4  byte-lane strobes; lane 0 = D31:24.
REQ-013 SHALL have port nWE  out  1  DRAM write enable.
REQ-014 SHALL have port DSACK  out  2  active-high, external open-drain inverter; 2'b11 = 32-bit port termination.

Function
REQ-015 SHALL register nDRAMSEL, nAS and nDS once on DRAM_CLK; all decisions below use the registered copies.
REQ-016 SHALL implement states IDLE, RAS, CASW, CAS, PRE, RFC, RFR.
REQ-017 IDLE: request = sel & as; ADDR, RnW, SIZ latched on exit; MA = row.
- refresh pending: go to RFC; refresh wins a simultaneous request.
- otherwise on request: go to RAS.
REQ-018 RAS, one cycle: nRAS[ADDR[27:26]] low, MA = row; go to CASW.
REQ-019 CASW: MA = column.
- read: go to CAS after one cycle.
- write: stay until registered nDS is low, then go to CAS.
REQ-020 CAS: nCAS low per lane enables, nWE = RnW, DSACK = 2'b11; held until registered nAS is high, then go to PRE.
REQ-021 Read lane enables SHALL be 4'b1111; write lane enables SHALL follow the 68030 32-bit-port table on {SIZ, ADDR[1:0]}, e.g. byte@3 = lane 3 only, long@0 = all four, word@1 = lanes 1-2.
REQ-022 Read latency SHALL be exactly 3 DRAM_CLK cycles from the IDLE-exit edge to DSACK assertion.
REQ-023 PRE: all nRAS/nCAS high, nWE high, DSACK 0 for TRP cycles, then IDLE.
REQ-024 Abort: registered nAS high in RAS or CASW SHALL go directly to PRE without asserting nCAS or DSACK.
REQ-025 Refresh counter SHALL free-run 0..REFRESH_DIV-1 and set pending at wrap.
- a wrap while pending is already set leaves it set; missed requests are not counted.
REQ-026 RFC, one cycle: all nCAS low, nRAS high (CAS-before-RAS); clears pending; go to RFR.
REQ-027 RFR: all nRAS and nCAS low for TRAS_REF cycles, then PRE; DSACK SHALL remain 0 throughout refresh.
REQ-028 nWE SHALL never be low outside CAS of a write; nCAS SHALL never be low in RAS or CASW.

Reset
REQ-029 On nRST low, asynchronously: state IDLE, nRAS 4'hF, nCAS 4'hF, nWE 1, MA 0, DSACK 0, refresh counter 0, pending 0, input registers inactive (high).
REQ-030 Reset mid-access SHALL release all strobes immediately; no precharge state is entered after reset.

Structure
REQ-031 SHALL place the state encoding and the lane-enable function ({SIZ, A[1:0]} -> 4-bit enables) in a shared package pg68k_bus_pkg, so the fast-RAM decode can reuse the same table.
REQ-032 SHALL place the refresh timer (counter plus pending flag) in one sub-module dramctl_refresh.

Verification
REQ-033 Reset: hold nRST low 5 cycles -> nRAS=F, nCAS=F, nWE=1, DSACK=0; no RFC before cycle 780 after release.
REQ-034 Long read at ADDR 0x4001234 -> nRAS[1] low, MA=0x000 then 0x48D, nCAS=0 and DSACK=11 on the 3rd cycle; 3 precharge cycles after nAS rises.
REQ-035 Byte write SIZ=01 at ADDR[1:0]=3, nDS delayed 4 cycles -> nCAS=4'b0111 and nWE=0 only after nDS is seen low.
REQ-036 Request on the same edge the refresh counter wraps -> RFC, RFR (4 cycles), PRE (3 cycles) complete first, then the access; DSACK arrives within 128 DRAM_CLK cycles.
REQ-037 nAS withdrawn during RAS -> no nCAS pulse, DSACK stays 0, PRE entered.
REQ-038 nRST asserted during CAS -> all strobes high and DSACK 0 before the next clock edge.
